delay_meter: RTL and testbench
==============================

DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 The block SHALL have the parameter CW, default 8, giving the width of the delay counter and result.
REQ-002 The block SHALL have the parameter MAX_WAIT, default 200, giving the timeout limit in cycles, legal range 1..2^CW-1.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have the port start, input, 1 bit: request one measurement.
REQ-006 The block SHALL have the port echo, input, 1 bit: the response from the path under test, synchronous to clk.
REQ-007 The block SHALL have the port stim, output, 1 bit: the launch edge driven into the path under test.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while not in IDLE.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse on a valid measurement.
REQ-010 The block SHALL have the port timeout, output, 1 bit: one-cycle pulse when no echo is seen within MAX_WAIT cycles.
REQ-011 The block SHALL have the port delay, output, CW bits: the last measured delay in clk cycles.

Function
REQ-012 The block SHALL use the states IDLE, WAIT and RELEASE.
REQ-013 In IDLE, start=1 with echo=0 at a rising edge (E0) SHALL move to WAIT, set stim=1 and clear the internal count to 0.
REQ-014 In IDLE, start=1 with echo=1 SHALL be ignored, with the state unchanged.
REQ-015 In WAIT, at edge Ek (k>=1), echo=1 SHALL load delay=k, pulse done for one cycle and move to RELEASE.
REQ-016 In WAIT, at edge Ek with echo=0 and k=MAX_WAIT, the block SHALL pulse timeout for one cycle, leave delay unchanged and move to RELEASE.
REQ-017 In WAIT, at edge Ek with echo=0 and k<MAX_WAIT, the count SHALL increment.
REQ-018 At edge MAX_WAIT, echo=1 SHALL take priority: done is pulsed with delay=MAX_WAIT, and timeout is not pulsed.
REQ-019 In RELEASE, stim SHALL be 0, and the block SHALL return to IDLE at the first edge that samples echo=0.
REQ-020 The block SHALL stay in RELEASE for as long as echo is held at 1.
REQ-021 stim SHALL be 1 only in WAIT and SHALL be driven from a register, so it is glitch-free.
REQ-022 busy SHALL be 1 in WAIT and RELEASE, and 0 in IDLE.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 delay SHALL hold its value until the next successful measurement, and a timeout SHALL NOT alter it.
REQ-025 done and timeout SHALL never be high in the same cycle.
REQ-026 Each of done and timeout SHALL be high for exactly one cycle per measurement.
REQ-027 The internal count SHALL never wrap, because the MAX_WAIT limit stops it first.

Reset
REQ-028 While rst=1, asynchronously and regardless of the clock, the block SHALL force state=IDLE, stim=0, busy=0, done=0, timeout=0, delay=0 and count=0.
REQ-029 When rst is asserted mid-measurement, stim SHALL drop immediately.
REQ-030 No done or timeout pulse SHALL follow the reset for the aborted measurement.
REQ-031 The first edge after rst deasserts SHALL evaluate start normally.

Verification
REQ-032 Basic measurement: start pulse, echo rises 3 cycles after stim -> delay=3, done pulses once, busy falls after echo falls.
REQ-033 Immediate echo: echo=1 sampled at E1 -> delay=1, then RELEASE holds while echo stays 1 for 10 cycles, then IDLE.
REQ-034 Timeout: MAX_WAIT=5, echo never rises -> timeout pulses at E5, delay keeps its prior value 3, stim=0 afterwards.
REQ-035 Boundary: MAX_WAIT=5, echo first high at E5 -> done=1, delay=5, timeout=0.
REQ-036 Protocol: start while busy, and start in IDLE with echo=1 -> both ignored, no stim edge, busy stays 0 in the IDLE case.
REQ-037 Reset mid-WAIT: rst asserted between clock edges at count 2 -> stim=0 immediately, all outputs 0, and the next start measures correctly.

Source files
------------

// File: rtl/delay_meter.sv
// Launch/echo round-trip delay meter: fires stim, counts cycles until echo,
// reports the delay or a timeout, then waits for echo to drop before re-arming.
module delay_meter #(
  parameter int unsigned CW       = 8,
  parameter int unsigned MAX_WAIT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          echo,
  output logic          stim,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] delay
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RELEASE
  } state_t;

  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] delay_q, delay_d;
  logic          stim_q, stim_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] k;

  assign k = count_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    delay_d   = delay_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !echo) begin
          state_d = WAIT;
          count_d = '0;
        end
      end
      WAIT: begin
        // echo wins over the limit on the final edge
        if (echo) begin
          delay_d = k;
          done_d  = 1'b1;
          state_d = RELEASE;
        end else if (k == MAX_W) begin
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          count_d = k;
        end
      end
      RELEASE: begin
        if (!echo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stim_d = (state_d == WAIT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      delay_q   <= '0;
      stim_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      delay_q   <= delay_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign stim    = stim_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign delay   = delay_q;

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter with MAX_WAIT=5.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_delay_meter;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          echo;
  logic          stim;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] delay;

  int checks = 0;
  int errors = 0;

  delay_meter #(.CW(CW), .MAX_WAIT(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .echo    (echo),
    .stim    (stim),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .delay   (delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("excl", 32'(done & timeout), 32'd0);
  endtask

  task automatic outs(input string tag,
                      input logic s, input logic b,
                      input logic d, input logic t,
                      input logic [CW-1:0] dl);
    check({tag, ".stim"},    32'(stim),    32'(s));
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".done"},    32'(done),    32'(d));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
    check({tag, ".delay"},   32'(delay),   32'(dl));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    echo = 1'b0;
    #2;
    outs("reset", 0, 0, 0, 0, 0);
    #5 rst = 1'b0;
    tick();
    outs("idle", 0, 0, 0, 0, 0);

    // basic: echo sampled high at E3
    start = 1'b1;
    tick();
    outs("b.E0", 1, 1, 0, 0, 0);
    start = 1'b0;
    tick();
    outs("b.E1", 1, 1, 0, 0, 0);
    tick();
    echo = 1'b1;
    tick();
    outs("b.E3", 0, 1, 1, 0, 3);
    tick();
    outs("b.hold", 0, 1, 0, 0, 3);
    echo = 1'b0;
    tick();
    outs("b.idle", 0, 0, 0, 0, 3);

    // timeout at E5, delay keeps 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      outs("t.wait", 1, 1, 0, 0, 3);
    end
    tick();
    outs("t.E5", 0, 1, 0, 1, 3);
    tick();
    outs("t.idle", 0, 0, 0, 0, 3);

    // boundary: echo first high at E5
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    outs("bd.E4", 1, 1, 0, 0, 3);
    echo = 1'b1;
    tick();
    outs("bd.E5", 0, 1, 1, 0, 5);
    echo = 1'b0;
    tick();
    outs("bd.idle", 0, 0, 0, 0, 5);

    // immediate echo, long release
    start = 1'b1;
    tick();
    start = 1'b0;
    echo = 1'b1;
    tick();
    outs("im.E1", 0, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      outs("im.rel", 0, 1, 0, 0, 1);
    end
    echo = 1'b0;
    tick();
    outs("im.idle", 0, 0, 0, 0, 1);

    // start with echo high in IDLE is ignored
    start = 1'b1;
    echo = 1'b1;
    tick();
    outs("p.echo", 0, 0, 0, 0, 1);
    tick();
    outs("p.echo2", 0, 0, 0, 0, 1);
    echo = 1'b0;

    // start held while busy does not restart the count
    tick();
    outs("p.E0", 1, 1, 0, 0, 1);
    tick();
    tick();
    echo = 1'b1;
    tick();
    outs("p.E3", 0, 1, 1, 0, 3);
    start = 1'b0;
    echo = 1'b0;
    tick();
    outs("p.idle", 0, 0, 0, 0, 3);

    // reset mid-WAIT at count 2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    outs("r.pre", 1, 1, 0, 0, 3);
    #2 rst = 1'b1;
    #1;
    outs("r.async", 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    start = 1'b1;
    tick();
    outs("r.E0", 1, 1, 0, 0, 0);
    start = 1'b0;
    tick();
    echo = 1'b1;
    tick();
    outs("r.E2", 0, 1, 1, 0, 2);
    echo = 1'b0;
    tick();
    outs("r.idle", 0, 0, 0, 0, 2);
    repeat (6) tick();
    outs("r.quiet", 0, 0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
